// File: rtl/serial_demux_n.sv
// Purpose : framed serial demultiplexer; start bit, port field, length field, then data bits routed to one of 2^PORT_BITS lines.
// Latency : P/Valid/Remain/Done update on the clkEn edge that samples the bit (visible one clk later); frame = 1+PORT_BITS+CNT_BITS+L clkEn edges.
// Backpressure: none; the serial line cannot be stalled, so every Valid pulse must be consumed in the clk cycle it is high.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   clkEn         bit-rate enable; protocol state only moves on edges where it is high
//   SerIn         serial input, idles high, start bit is a 0
//   P[NP]         per-port data lines, only the selected port can be non-zero
//   Valid[NP]     one-clk pulse per data bit delivered on the selected port
//   PortSel       port number of the current or most recent frame
//   Remain        data bits still expected in the current frame
//   Busy          high while a frame is being received
//   Done          one-clk pulse when a frame finishes

module serial_demux_n #(
    parameter int PORT_BITS = 2,
    parameter int CNT_BITS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clkEn,
    input  logic                        SerIn,
    output logic [(1<<PORT_BITS)-1:0]   P,
    output logic [(1<<PORT_BITS)-1:0]   Valid,
    output logic [PORT_BITS-1:0]        PortSel,
    output logic [CNT_BITS-1:0]         Remain,
    output logic                        Busy,
    output logic                        Done
);

    localparam int NP = 1 << PORT_BITS;
    // One counter serves both header fields, so it must cover the wider one.
    localparam int CW = (PORT_BITS > CNT_BITS) ? PORT_BITS : CNT_BITS;

    localparam logic [CW-1:0] PORT_LAST = CW'(PORT_BITS - 1);
    localparam logic [CW-1:0] LEN_LAST  = CW'(CNT_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PORT = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [CW-1:0]          bit_cnt_q;
    logic [CW-1:0]          bit_cnt_d;
    logic [PORT_BITS-1:0]   port_sh_q;
    logic [PORT_BITS-1:0]   port_sh_d;
    logic [CNT_BITS-1:0]    len_sh_q;
    logic [CNT_BITS-1:0]    len_sh_d;
    logic [PORT_BITS-1:0]   port_sel_q;
    logic [PORT_BITS-1:0]   port_sel_d;
    logic [CNT_BITS-1:0]    remain_q;
    logic [CNT_BITS-1:0]    remain_d;
    logic [NP-1:0]          p_q;
    logic [NP-1:0]          p_d;
    logic [NP-1:0]          valid_q;
    logic [NP-1:0]          valid_d;
    logic                   done_q;
    logic                   done_d;

    // Field values including the bit being sampled this edge (MSB first).
    logic [PORT_BITS-1:0]   port_next;
    logic [CNT_BITS-1:0]    len_next;
    logic                   port_last_bit;
    logic                   len_last_bit;

    assign port_next     = (port_sh_q << 1) | PORT_BITS'(SerIn);
    assign len_next      = (len_sh_q  << 1) | CNT_BITS'(SerIn);
    assign port_last_bit = (bit_cnt_q == PORT_LAST);
    assign len_last_bit  = (bit_cnt_q == LEN_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clkEn) begin
            case (state_q)
                ST_IDLE: begin
                    if (!SerIn) begin
                        state_d = ST_PORT;
                    end
                end
                ST_PORT: begin
                    if (port_last_bit) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (len_last_bit) begin
                        // A zero-length frame has no data phase at all.
                        state_d = (len_next == '0) ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    // <= 1 rather than == 1 so a corrupted zero count still
                    // returns to IDLE instead of sitting in DATA forever.
                    if (remain_q <= CNT_BITS'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        port_sh_d  = port_sh_q;
        len_sh_d   = len_sh_q;
        port_sel_d = port_sel_q;
        remain_d   = remain_q;
        p_d        = p_q;          // data lines hold between clkEn edges
        valid_d    = '0;           // pulses always clear on the next clk
        done_d     = 1'b0;

        if (clkEn) begin
            // Any enabled edge that does not carry a data bit clears P,
            // which limits each delivered bit to exactly one bit period.
            p_d = '0;

            case (state_q)
                ST_PORT: begin
                    port_sh_d = port_next;
                    // PortSel only changes once the whole field is known, so
                    // the previous frame's port stays visible during shifting.
                    if (port_last_bit) begin
                        port_sel_d = port_next;
                    end
                end
                ST_LEN: begin
                    len_sh_d = len_next;
                    if (len_last_bit && (len_next != '0)) begin
                        remain_d = len_next;
                    end
                end
                ST_DATA: begin
                    p_d[port_sel_q]     = SerIn;
                    valid_d[port_sel_q] = 1'b1;
                    remain_d = (remain_q == '0) ? '0 : (remain_q - CNT_BITS'(1));
                end
                default: begin
                end
            endcase

            // Frame end is any exit to IDLE from a header/data state.
            done_d = ((state_q == ST_LEN) || (state_q == ST_DATA)) &&
                     (state_d == ST_IDLE);

            // Counter restarts on every state change and only counts in
            // the two header-field states.
            if (state_d != state_q) begin
                bit_cnt_d = '0;
            end else if ((state_q == ST_PORT) || (state_q == ST_LEN)) begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end else begin
                bit_cnt_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            port_sh_q  <= '0;
            len_sh_q   <= '0;
            port_sel_q <= '0;
            remain_q   <= '0;
            p_q        <= '0;
            valid_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            port_sh_q  <= port_sh_d;
            len_sh_q   <= len_sh_d;
            port_sel_q <= port_sel_d;
            remain_q   <= remain_d;
            p_q        <= p_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign P       = p_q;
    assign Valid   = valid_q;
    assign PortSel = port_sel_q;
    assign Remain  = remain_q;
    assign Done    = done_q;
    // Derived from the state register, so it falls together with Done.
    assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_demux_n.sv
// Purpose : bench for serial_demux_n at default widths (dut_a) and at PORT_BITS=3, CNT_BITS=5 (dut_b).
// Latency : expectations are taken one step after each clkEn edge and on every idle clk in between.
// Backpressure: none; the bench drives one bit per clkEn edge.

module tb_serial_demux_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       ser_a;
    logic       ser_b;

    logic [3:0] p_a, valid_a, remain_a;
    logic [1:0] portsel_a;
    logic       busy_a, done_a;

    logic [7:0] p_b, valid_b;
    logic [2:0] portsel_b;
    logic [4:0] remain_b;
    logic       busy_b, done_b;

    int n_vec = 0;
    int n_err = 0;
    int prev_port [2];
    int fdata [64];

    logic [31:0] o_p, o_v, o_ps, o_rem;
    logic        o_busy, o_done;

    always #5 clk = ~clk;

    serial_demux_n #(.PORT_BITS(2), .CNT_BITS(4)) dut_a (
        .clk(clk), .rst(rst), .clkEn(clk_en), .SerIn(ser_a),
        .P(p_a), .Valid(valid_a), .PortSel(portsel_a), .Remain(remain_a),
        .Busy(busy_a), .Done(done_a)
    );

    serial_demux_n #(.PORT_BITS(3), .CNT_BITS(5)) dut_b (
        .clk(clk), .rst(rst), .clkEn(clk_en), .SerIn(ser_b),
        .P(p_b), .Valid(valid_b), .PortSel(portsel_b), .Remain(remain_b),
        .Busy(busy_b), .Done(done_b)
    );

    // Copy the observed outputs of one instance into width-neutral variables.
    task automatic sample(input bit wide);
        o_p    = wide ? 32'(p_b)       : 32'(p_a);
        o_v    = wide ? 32'(valid_b)   : 32'(valid_a);
        o_ps   = wide ? 32'(portsel_b) : 32'(portsel_a);
        o_rem  = wide ? 32'(remain_b)  : 32'(remain_a);
        o_busy = wide ? busy_b : busy_a;
        o_done = wide ? done_b : done_a;
    endtask

    // One clkEn edge carrying bit b to the chosen instance; returns 1 after the edge.
    task automatic en_edge(input bit wide, input bit b);
        @(negedge clk);
        if (wide) begin ser_b = b; ser_a = 1'b1; end
        else      begin ser_a = b; ser_b = 1'b1; end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
    endtask

    // Sends a frame (data from fdata[]) and predicts every output from the
    // frame layout: edge k=0 is the start bit, then pb port bits, cb length
    // bits, then len data bits. lim<0 sends the full frame; otherwise stops
    // right after edge lim-1. sp<=0 picks a random clkEn spacing per edge.
    task automatic run_frame(input bit wide, input int port, input int len,
                             input int sp, input int lim, input int freeze_at);
        int pb, cb, nb, last, gap, j, stop;
        int bits [80];
        logic [31:0] e_p, e_v, e_ps, e_rem;
        logic        e_busy, e_done;
        pb = wide ? 3 : 2;
        cb = wide ? 5 : 4;
        nb = 0;
        bits[nb] = 0; nb++;
        for (int i = pb - 1; i >= 0; i--) begin bits[nb] = (port >> i) & 1; nb++; end
        for (int i = cb - 1; i >= 0; i--) begin bits[nb] = (len >> i) & 1;  nb++; end
        for (int i = 0; i < len; i++)     begin bits[nb] = fdata[i];        nb++; end
        last = nb - 1;
        stop = (lim < 0) ? nb : lim;
        for (int k = 0; k < stop; k++) begin
            en_edge(wide, bits[k] != 0);
            j      = k - (pb + cb) - 1;
            e_v    = (j >= 0) ? (32'd1 << port) : 32'd0;
            e_p    = (j >= 0 && fdata[j] != 0) ? (32'd1 << port) : 32'd0;
            e_ps   = (k >= pb) ? 32'(port) : 32'(prev_port[int'(wide)]);
            e_rem  = (k >= pb + cb) ? 32'(len - (k - pb - cb)) : 32'd0;
            e_busy = (k != last);
            e_done = (k == last);
            if (k >= pb) prev_port[int'(wide)] = port;
            sample(wide);
            n_vec++; if (o_p    !== e_p)    begin n_err++; $display("FAIL p w=%0d edge %0d: got %0h want %0h", wide, k, o_p, e_p); end
            n_vec++; if (o_v    !== e_v)    begin n_err++; $display("FAIL valid w=%0d edge %0d: got %0h want %0h", wide, k, o_v, e_v); end
            n_vec++; if (o_ps   !== e_ps)   begin n_err++; $display("FAIL portsel w=%0d edge %0d: got %0h want %0h", wide, k, o_ps, e_ps); end
            n_vec++; if (o_rem  !== e_rem)  begin n_err++; $display("FAIL remain w=%0d edge %0d: got %0d want %0d", wide, k, o_rem, e_rem); end
            n_vec++; if (o_busy !== e_busy) begin n_err++; $display("FAIL busy w=%0d edge %0d: got %b want %b", wide, k, o_busy, e_busy); end
            n_vec++; if (o_done !== e_done) begin n_err++; $display("FAIL done w=%0d edge %0d: got %b want %b", wide, k, o_done, e_done); end
            if (k != stop - 1 || stop == nb) begin
                gap = ((sp > 0) ? sp : int'($urandom_range(1, 4))) - 1 + ((k == freeze_at) ? 10 : 0);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                    sample(wide);
                    n_vec++; if (o_v    !== 32'd0)  begin n_err++; $display("FAIL hold_valid w=%0d edge %0d: got %0h want 0", wide, k, o_v); end
                    n_vec++; if (o_done !== 1'b0)   begin n_err++; $display("FAIL hold_done w=%0d edge %0d: got %b want 0", wide, k, o_done); end
                    n_vec++; if (o_p    !== e_p)    begin n_err++; $display("FAIL hold_p w=%0d edge %0d: got %0h want %0h", wide, k, o_p, e_p); end
                    n_vec++; if (o_ps   !== e_ps)   begin n_err++; $display("FAIL hold_portsel w=%0d edge %0d: got %0h want %0h", wide, k, o_ps, e_ps); end
                    n_vec++; if (o_rem  !== e_rem)  begin n_err++; $display("FAIL hold_remain w=%0d edge %0d: got %0d want %0d", wide, k, o_rem, e_rem); end
                    n_vec++; if (o_busy !== e_busy) begin n_err++; $display("FAIL hold_busy w=%0d edge %0d: got %b want %b", wide, k, o_busy, e_busy); end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b0; ser_a = 1'b1; ser_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            sample(w != 0);
            n_vec++; if (o_p    !== 32'd0) begin n_err++; $display("FAIL reset_p w=%0d: got %0h want 0", w, o_p); end
            n_vec++; if (o_v    !== 32'd0) begin n_err++; $display("FAIL reset_valid w=%0d: got %0h want 0", w, o_v); end
            n_vec++; if (o_ps   !== 32'd0) begin n_err++; $display("FAIL reset_portsel w=%0d: got %0h want 0", w, o_ps); end
            n_vec++; if (o_rem  !== 32'd0) begin n_err++; $display("FAIL reset_remain w=%0d: got %0h want 0", w, o_rem); end
            n_vec++; if (o_busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy w=%0d: got %b want 0", w, o_busy); end
            n_vec++; if (o_done !== 1'b0)  begin n_err++; $display("FAIL reset_done w=%0d: got %b want 0", w, o_done); end
        end
        prev_port[0] = 0;
        prev_port[1] = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        fdata[0] = 1; fdata[1] = 0; fdata[2] = 1;
        run_frame(1'b0, 2, 3, 4, -1, -1);
        en_edge(1'b0, 1'b1);
        sample(1'b0);
        n_vec++; if (o_p    !== 32'd0) begin n_err++; $display("FAIL basic_p_after: got %0h want 0", o_p); end
        n_vec++; if (o_busy !== 1'b0)  begin n_err++; $display("FAIL basic_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_zero_length();
        int len;
        run_frame(1'b0, 1, 0, 0, -1, -1);
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) fdata[i] = $urandom_range(0, 1);
        run_frame(1'b0, $urandom_range(0, 3), len, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) fdata[i] = $urandom_range(0, 1);
        run_frame(1'b0, 3, 15, 0, -1, -1);
        fdata[0] = 1;
        run_frame(1'b0, 0, 1, 0, -1, -1);
    endtask

    task automatic test_reset_mid_data();
        for (int i = 0; i < 5; i++) fdata[i] = $urandom_range(0, 1);
        // 1 start + 2 port + 4 length + 2 data edges, then abort.
        run_frame(1'b0, 1, 5, 2, 9, -1);
        #2;
        rst = 1'b1;
        #1;
        sample(1'b0);
        n_vec++; if (o_p    !== 32'd0) begin n_err++; $display("FAIL midrst_p: got %0h want 0", o_p); end
        n_vec++; if (o_v    !== 32'd0) begin n_err++; $display("FAIL midrst_valid: got %0h want 0", o_v); end
        n_vec++; if (o_ps   !== 32'd0) begin n_err++; $display("FAIL midrst_portsel: got %0h want 0", o_ps); end
        n_vec++; if (o_rem  !== 32'd0) begin n_err++; $display("FAIL midrst_remain: got %0h want 0", o_rem); end
        n_vec++; if (o_busy !== 1'b0)  begin n_err++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
        @(negedge clk);
        rst = 1'b0;
        prev_port[0] = 0;
        prev_port[1] = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got %b want 0", done_a); end
            n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got %b want 0", busy_a); end
        end
        for (int i = 0; i < 5; i++) fdata[i] = $urandom_range(0, 1);
        run_frame(1'b0, 2, 5, 0, -1, -1);
    endtask

    task automatic test_wide_ports();
        int len;
        for (int i = 0; i < 17; i++) fdata[i] = $urandom_range(0, 1);
        run_frame(1'b1, 7, 17, 0, -1, -1);
        len = $urandom_range(1, 31);
        for (int i = 0; i < len; i++) fdata[i] = $urandom_range(0, 1);
        run_frame(1'b1, $urandom_range(0, 7), len, 0, -1, -1);
    endtask

    task automatic test_idle_noise();
        for (int i = 0; i < 20; i++) begin
            en_edge(1'b0, 1'b1);
            sample(1'b0);
            n_vec++; if (o_busy !== 1'b0)  begin n_err++; $display("FAIL idle_busy edge %0d: got %b want 0", i, o_busy); end
            n_vec++; if (o_p    !== 32'd0) begin n_err++; $display("FAIL idle_p edge %0d: got %0h want 0", i, o_p); end
            n_vec++; if (o_v    !== 32'd0) begin n_err++; $display("FAIL idle_valid edge %0d: got %0h want 0", i, o_v); end
        end
        for (int i = 0; i < 3; i++) fdata[i] = $urandom_range(0, 1);
        // Edge 4 lies inside the length field; clkEn then stays low for 10 extra clks.
        run_frame(1'b0, $urandom_range(0, 3), 3, 2, -1, 4);
    endtask

    task automatic test_random_frames();
        int len;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(0, 15);
            for (int i = 0; i < len; i++) fdata[i] = $urandom_range(0, 1);
            run_frame(1'b0, $urandom_range(0, 3), len, 0, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_zero_length();
        test_back_to_back();
        test_reset_mid_data();
        test_wide_ports();
        test_idle_noise();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/serial_demux_n.md
# serial_demux_n

Parametrised serial frame demultiplexer with an integrated controller. It receives a framed bit stream on `SerIn` at the rate set by `clkEn`: start bit, port number, data length, then data bits. Each data bit is routed to one of 2^PORT_BITS registered output lines. It sits between the serial input pin and the per-port consumers, and exports the remaining-bit count for the seven-segment display path.

## Interface
- `PORT_BITS`, default 2: width of the port field. Number of ports NP = 2^PORT_BITS.
- `CNT_BITS`, default 4: width of the length field. Maximum frame length is 2^CNT_BITS-1 data bits.

- `clk`  in  1  system clock; all registers use the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clkEn`  in  1  bit-rate enable. Protocol state advances only on edges where `clkEn`=1.
- `SerIn`  in  1  serial input. The line idles high.
- `P`  out  NP  registered per-port data lines.
- `Valid`  out  NP  one-`clk` pulse per delivered bit on the selected port.
- `PortSel`  out  PORT_BITS  latched port number of the current or last frame.
- `Remain`  out  CNT_BITS  data bits still expected in the current frame.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Done`  out  1  one-`clk` pulse at frame end.

## Operation
- **States:** IDLE, PORT, LEN, DATA. An internal bit counter of width max(PORT_BITS, CNT_BITS) is cleared on every state change.
- **IDLE:** on a clkEn edge with `SerIn`=0 (start bit), go to PORT.
- **PORT:** shift `SerIn` into the port register, MSB first. After PORT_BITS samples, `PortSel` holds the full value and the state goes to LEN.
- **LEN:** shift `SerIn` into the length register, MSB first. On the sample that completes the field:
  - length = 0: go to IDLE, pulse `Done`, no data phase.
  - otherwise: go to DATA and load `Remain` with the length.
- **DATA:** on each clkEn edge:
  - `P[PortSel]` ← `SerIn`.
  - `Valid[PortSel]` pulses.
  - `Remain` decrements.
  - When `Remain` was 1: go to IDLE, pulse `Done`, and `Remain` becomes 0.
- **P lines:**
  - On any clkEn edge that does not sample a data bit, all `P` ← 0.
  - Non-selected `P` lines are always 0.
  - Each data bit is therefore held for exactly one clkEn period.
- **Back-to-back frames:** a start bit may arrive on the first clkEn edge after the frame ends. No idle gap is required.
- **clkEn = 0:** state, counters, `P`, `PortSel` and `Remain` hold. `Valid` and `Done` still clear on the next `clk` edge.
- `Remain` saturates at 0. Decrements never wrap.

## Timing
- **Reset values:** state IDLE; `P`=0, `Valid`=0, `PortSel`=0, `Remain`=0, `Busy`=0, `Done`=0; shift registers and bit counter 0.
- **Reset mid-frame:** the frame is abandoned immediately and asynchronously. No `Done` is issued. The first start bit after `rst` deasserts begins a new frame.
- **Per-bit latency:** `P`/`Valid` update on the same edge that samples the data bit, so they are visible one `clk` after it.
- **Frame latency:** a frame of length L occupies 1 + PORT_BITS + CNT_BITS + L clkEn edges.
- **Done:** asserted in the `clk` cycle after the edge that sampled the last bit (the last data bit, or the last length bit when L=0).
- **Pulse width:** `Valid` and `Done` are exactly one `clk` cycle wide regardless of clkEn spacing.
- **Busy:** rises one `clk` after the start-bit edge. Falls one `clk` after the final edge, coincident with `Done`.

## Test plan
- **Basic frame** (defaults, clkEn every 4 clks). Send 0 | 10 | 0011 | 1,0,1.
  - `PortSel`=2.
  - `Remain` goes 3→2→1→0.
  - `P[2]` = 1,0,1, each held 4 clks.
  - Three `Valid[2]` pulses.
  - `Done` one clk after the last bit. `P`=0 afterwards, `P[0,1,3]` always 0.
- **Zero length.** Send 0 | 01 | 0000.
  - `Done` after the 7th edge.
  - No `Valid`; `P` stays 0.
  - Next start bit accepted.
- **Maximum length and back-to-back.** Send 0 | 11 | 1111 | 15 bits, then immediately 0 | 00 | 0001 | 1.
  - 15 `Valid[3]` pulses, `Done`.
  - Then `Valid[0]`, `P[0]`=1, second `Done`. No bits lost.
- **Reset mid-DATA.** Assert `rst` asynchronously, off a `clk` edge, after 2 of 5 data bits.
  - All outputs 0 immediately.
  - No `Done`.
  - A subsequent full frame delivers correctly.
- **Wider ports.** PORT_BITS=3, CNT_BITS=5. Send port 7, length 17.
  - 17 bits appear on `P[7]`.
  - `Remain` starts at 17.
  - Other 7 lines stay 0.
- **Idle noise / clkEn gating.** `SerIn` held high for 20 clkEn edges, then clkEn held low for 10 clks mid-LEN.
  - `Busy`=0 throughout the idle period.
  - State frozen while clkEn is low.
  - Frame then completes normally.
